pong_vga_render: RTL and testbench

//  Display-side consumer of the CPU game-state exports (ball X/Y, left/right paddle Y, busy).

---
 rtl/pong_vga_render.sv | 224 ++++++++++++++++++++++
 tb/tb_pong_vga_render.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pong_vga_render.sv
// VGA renderer for the Pong game state: generates raster timing and draws ball, paddles and net
// from coordinates that are shadowed once per frame while the CPU is idle.
module pong_vga_render #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int BALL_SZ  = 8,
    parameter int BAR_W    = 8,
    parameter int BAR_H    = 64,
    parameter int BAR_E_X  = 16,
    parameter int BAR_D_X  = 616
) (
    input  logic       clk_clk,
    input  logic       rst_export,
    input  logic [9:0] bola_x,
    input  logic [9:0] bola_y,
    input  logic [9:0] barra_e_y,
    input  logic [9:0] barra_d_y,
    input  logic [7:0] busy,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PIX_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [10:0] BALL_LEN  = 11'(BALL_SZ);
    localparam logic [10:0] BAR_W_LEN = 11'(BAR_W);
    localparam logic [10:0] BAR_H_LEN = 11'(BAR_H);
    localparam logic [10:0] BAR_E_X0  = 11'(BAR_E_X);
    localparam logic [10:0] BAR_D_X0  = 11'(BAR_D_X);
    localparam logic [10:0] NET_X0    = 11'(H_ACTIVE / 2 - 2);
    localparam logic [10:0] NET_LEN   = 11'd4;

    localparam logic [9:0] BALL_X_RST = 10'(H_ACTIVE / 2 - BALL_SZ / 2);
    localparam logic [9:0] BALL_Y_RST = 10'(V_ACTIVE / 2 - BALL_SZ / 2);
    localparam logic [9:0] BAR_Y_RST  = 10'(V_ACTIVE / 2 - BAR_H / 2);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } latch_state_t;

    // Half-open span test done one bit wider than the coordinates so lo+len cannot wrap.
    function automatic logic in_span(input logic [10:0] p, input logic [10:0] lo,
                                     input logic [10:0] len);
        return (p >= lo) && (p < lo + len);
    endfunction

    logic [PIX_W-1:0] pix_cnt;
    logic             pe;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             h_last;
    logic             v_last;
    logic             line_start;
    logic             in_vblank;

    latch_state_t     state;
    latch_state_t     state_nxt;
    logic             latch_en;

    logic [9:0]       sh_bx;
    logic [9:0]       sh_by;
    logic [9:0]       sh_ey;
    logic [9:0]       sh_dy;

    logic [10:0]      x_p0;
    logic [10:0]      y_p0;
    logic             vld_p0;
    logic             hs_p0;
    logic             vs_p0;
    logic             hit_p0;

    logic             vld_p1;
    logic             hs_p1;
    logic             vs_p1;
    logic [3:0]       rgb_p1;
    logic             tick_p1;

    assign pe         = (pix_cnt == PIX_LAST);
    assign h_last     = (h_cnt == H_LAST);
    assign v_last     = (v_cnt == V_LAST);
    assign line_start = pe && (h_cnt == 10'd0);
    assign in_vblank  = (v_cnt >= V_ACT);

    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            pix_cnt <= '0;
        end else if (pe) begin
            pix_cnt <= '0;
        end else begin
            pix_cnt <= pix_cnt + PIX_W'(1);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pe) begin
            h_cnt <= h_last ? 10'd0 : h_cnt + 10'd1;
            if (h_last) begin
                v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // PEND keeps retrying at each vblank line start; giving up at frame wrap keeps old shadows.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (line_start && (v_cnt == V_ACT) && (busy != 8'd0)) begin
                    state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (line_start && in_vblank && (busy == 8'd0)) begin
                    state_nxt = S_IDLE;
                end else if (pe && h_last && v_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        latch_en = 1'b0;
        case (state)
            S_IDLE:  latch_en = line_start && (v_cnt == V_ACT) && (busy == 8'd0);
            S_PEND:  latch_en = line_start && in_vblank && (busy == 8'd0);
            default: latch_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            sh_bx   <= BALL_X_RST;
            sh_by   <= BALL_Y_RST;
            sh_ey   <= BAR_Y_RST;
            sh_dy   <= BAR_Y_RST;
            tick_p1 <= 1'b0;
        end else begin
            tick_p1 <= latch_en;
            if (latch_en) begin
                sh_bx <= bola_x;
                sh_by <= bola_y;
                sh_ey <= barra_e_y;
                sh_dy <= barra_d_y;
            end
        end
    end

    // Stage p0: decode timing and object hits from the live counters.
    assign x_p0 = {1'b0, h_cnt};
    assign y_p0 = {1'b0, v_cnt};

    always_comb begin
        vld_p0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_p0  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs_p0  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        hit_p0 = (in_span(x_p0, {1'b0, sh_bx}, BALL_LEN) && in_span(y_p0, {1'b0, sh_by}, BALL_LEN))
              || (in_span(x_p0, BAR_E_X0, BAR_W_LEN) && in_span(y_p0, {1'b0, sh_ey}, BAR_H_LEN))
              || (in_span(x_p0, BAR_D_X0, BAR_W_LEN) && in_span(y_p0, {1'b0, sh_dy}, BAR_H_LEN))
              || (in_span(x_p0, NET_X0, NET_LEN) && !v_cnt[4]);
    end

    // Stage p1: registered video outputs, one pixel behind the counters.
    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b1;
            vs_p1  <= 1'b1;
            rgb_p1 <= 4'h0;
        end else if (pe) begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            rgb_p1 <= (vld_p0 && hit_p0) ? 4'hF : 4'h0;
        end
    end

    assign vga_hs     = hs_p1;
    assign vga_vs     = vs_p1;
    assign vga_de     = vld_p1;
    assign vga_r      = rgb_p1;
    assign vga_g      = rgb_p1;
    assign vga_b      = rgb_p1;
    assign frame_tick = tick_p1;

endmodule

// File: tb/tb_pong_vga_render.sv
// Randomized bench for pong_vga_render on a reduced raster; every sampled clock is compared
// against a pixel-index model of timing, drawing and the per-frame shadow latch rule.
module tb_pong_vga_render;

    localparam int HA = 48, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 32, VFP = 2, VSW = 2, VBP = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME_PX = HT * VT;
    localparam int BALL = 8, BW = 4, BH = 16, BEX = 4, BDX = 40;
    localparam logic [14:0] RST_OUT = {1'b1, 1'b1, 1'b0, 12'h000};

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] bola_x, bola_y, barra_e_y, barra_d_y;
    logic [7:0] busy;
    logic       vga_hs, vga_vs, vga_de, frame_tick;
    logic [3:0] vga_r, vga_g, vga_b;

    always #5 clk = ~clk;

    pong_vga_render #(
        .CLK_DIV(2), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .BALL_SZ(BALL), .BAR_W(BW), .BAR_H(BH), .BAR_E_X(BEX), .BAR_D_X(BDX)
    ) dut (
        .clk_clk(clk), .rst_export(rst),
        .bola_x(bola_x), .bola_y(bola_y), .barra_e_y(barra_e_y), .barra_d_y(barra_d_y),
        .busy(busy),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_tick(frame_tick)
    );

    int total = 0;
    int bad = 0;
    int c = 0;
    int fr = 0;
    int scen = 0;
    int dly = 1;
    int m_bx, m_by, m_ey, m_dy;
    bit m_done;
    bit first_run = 1'b1;
    logic [14:0] last_exp = RST_OUT;
    int de_cnt = 0;
    int hs_low = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_span(input int p, input int lo, input int len);
        return (p >= lo) && (p < lo + len);
    endfunction

    // Expected {hs, vs, de, r, g, b} for raster position (h, v) using the model shadows.
    function automatic logic [14:0] pix_out(input int h, input int v);
        bit de, hs, vs, hit;
        logic [3:0] col;
        de  = (h < HA) && (v < VA);
        hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        hit = (in_span(h, m_bx, BALL) && in_span(v, m_by, BALL))
           || (in_span(h, BEX, BW) && in_span(v, m_ey, BH))
           || (in_span(h, BDX, BW) && in_span(v, m_dy, BH))
           || (h >= HA / 2 - 2 && h < HA / 2 + 2 && ((v / 16) % 2) == 0);
        col = (de && hit) ? 4'hF : 4'h0;
        return {hs, vs, de, col, col, col};
    endfunction

    task automatic model_reset();
        m_bx   = HA / 2 - BALL / 2;
        m_by   = VA / 2 - BALL / 2;
        m_ey   = VA / 2 - BH / 2;
        m_dy   = VA / 2 - BH / 2;
        m_done = 1'b0;
    endtask

    function automatic logic [9:0] rnd_coord(input int span);
        if ($urandom_range(0, 3) == 0) return 10'($urandom_range(0, 1023));
        return 10'($urandom_range(0, span + 4));
    endfunction

    task automatic randomize_coords();
        bola_x    = rnd_coord(HA);
        bola_y    = rnd_coord(VA);
        barra_e_y = rnd_coord(VA);
        barra_d_y = rnd_coord(VA);
    endtask

    // Called mid-line; sets the inputs the DUT will see at the start of line nv.
    task automatic drive(input int v);
        int nv;
        logic [7:0] nz;
        nv = (v + 1) % VT;
        nz = 8'($urandom_range(1, 255));
        if (nv == 0) fr++;
        if (nv == 2) begin
            case (fr)
                0: begin
                    bola_x = 10'(HA - 4); bola_y = 10'(VA - 10);
                    barra_e_y = 10'(VA - 6); barra_d_y = 10'd1020;
                end
                1: begin
                    bola_x = 10'd1020; bola_y = 10'd3;
                    barra_e_y = 10'd0; barra_d_y = 10'(VA - 16);
                end
                default: randomize_coords();
            endcase
        end else if (fr >= 3 && $urandom_range(0, 7) == 0) begin
            randomize_coords();
        end
        if (nv == VA) begin
            case (fr)
                0: scen = 0;
                1: begin scen = 1; dly = 4; end
                2: scen = 2;
                default: begin
                    scen = $urandom_range(0, 3);
                    dly  = $urandom_range(1, VT - VA - 1);
                end
            endcase
        end
        if (nv >= VA) begin
            case (scen)
                0: busy = 8'd0;
                1: busy = (nv < VA + dly) ? nz : 8'd0;
                2: busy = nz;
                default: busy = ($urandom_range(0, 2) == 0) ? 8'd0 : nz;
            endcase
        end else begin
            busy = 8'($urandom);
        end
    endtask

    task automatic step();
        logic [14:0] e;
        logic t;
        int k, h, v;
        bit do_drive;
        @(negedge clk);
        if (rst) begin
            c = 0;
            model_reset();
        end else begin
            c++;
        end
        t = 1'b0;
        do_drive = 1'b0;
        h = 0;
        v = 0;
        if (c < 2) begin
            e = RST_OUT;
        end else begin
            k = (c - 2) / 2;
            h = k % HT;
            v = (k / HT) % VT;
            if (c % 2 == 0) begin
                if (h == 0 && v == 0) m_done = 1'b0;
                e = pix_out(h, v);
                if (h == 0 && v >= VA && !m_done && busy == 8'd0) begin
                    t = 1'b1;
                    m_done = 1'b1;
                    m_bx = int'(bola_x);
                    m_by = int'(bola_y);
                    m_ey = int'(barra_e_y);
                    m_dy = int'(barra_d_y);
                end
                last_exp = e;
                if (first_run && k < FRAME_PX) begin
                    de_cnt += int'(vga_de);
                    hs_low += int'(!vga_hs);
                end
                do_drive = (h == HT / 2);
            end else begin
                e = last_exp;
            end
        end
        check($sformatf("px c=%0d h=%0d v=%0d", c, h, v),
              {vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, frame_tick}, {e, t});
        if (do_drive) drive(v);
    endtask

    initial begin
        rst = 1'b1;
        busy = 8'd0;
        bola_x = 10'd0; bola_y = 10'd0; barra_e_y = 10'd0; barra_d_y = 10'd0;
        model_reset();
        repeat (3) step();
        rst = 1'b0;
        repeat (2 * (5 * FRAME_PX + 20 * HT + 10)) step();
        first_run = 1'b0;
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (2 * 3 * FRAME_PX) step();
        check("de_cnt", 16'(de_cnt), 16'(HA * VA));
        check("hs_low", 16'(hs_low), 16'(HSW * VT));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
